// File: rtl/mips_pkg.sv
// Shared constants for the MIPS execute stage: pipeline register layouts,
// ALUOp/funct encodings and the multiply/divide iteration count.
package mips_pkg;

  localparam int MD_CYCLES_DEF = 32;
  localparam int DATA_W        = 32;

  localparam int IDEX_W        = 136;
  localparam int EXME_W        = 75;

  localparam int IDEX_INSTR_LSB = 0;
  localparam int IDEX_RS_LSB    = 32;
  localparam int IDEX_RT_LSB    = 64;
  localparam int IDEX_IMM_LSB   = 96;
  localparam int IDEX_REGDST    = 135;
  localparam int IDEX_MEMREAD   = 134;
  localparam int IDEX_MEMTOREG  = 133;
  localparam int IDEX_ALUOP_LSB = 131;
  localparam int IDEX_MEMWRITE  = 130;
  localparam int IDEX_ALUSRC    = 129;
  localparam int IDEX_REGWRITE  = 128;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ZERO  = 2'b11;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // funct[1:0] of the four multiply/divide instructions selects the operation
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } mdOp_e;

  // Packed in EXMEReg bit order, MSB first
  typedef struct packed {
    logic [1:0]  reserved;
    logic        memRead;
    logic        memtoReg;
    logic        memWrite;
    logic        regWrite;
    logic [4:0]  writeReg;
    logic [31:0] storeData;
    logic [31:0] aluResult;
  } exmeFields_t;

  function automatic logic isMdFunct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Pipeline-register bundle between decode, execute and memory stages.
interface execute_stage_if;
  import mips_pkg::*;

  logic [IDEX_W-1:0] IDEXReg;
  logic [EXME_W-1:0] EXMEReg;
  logic              exStall;

  modport master (output IDEXReg, input EXMEReg, input exStall);
  modport slave  (input IDEXReg, output EXMEReg, output exStall);
endinterface

// File: rtl/execute_stage_muldiv.sv
// Iterative 32-step shift-add multiplier / restoring divider with HI/LO.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(MD_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(MD_CYCLES - 1);
  localparam logic [0:0] MD_IDLE = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  function automatic logic [31:0] magnitude(input logic signed [31:0] v, input logic isSigned);
    logic [31:0] r;
    r = (isSigned && v < 0) ? 32'(-v) : 32'(v);
    return r;
  endfunction

  function automatic logic [31:0] fixSign32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] fixSign64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic             isDiv, negQ, negR, divZero;
  logic [31:0]      dividend, mcand, accHi, accLo;
  logic [31:0]      hiReg, loReg;

  logic             isSigned;
  logic [31:0]      magA, magB;
  logic [32:0]      multSum, divShift;
  logic             divGe;
  logic [31:0]      accHiNext, accLoNext, hiNext, loNext, quot, rem;
  logic [63:0]      product;

  assign isSigned = ~op[0];
  assign magA     = magnitude(a, isSigned);
  assign magB     = magnitude(b, isSigned);

  // One iteration: mult adds then shifts {accHi,accLo} right; div shifts left then trial-subtracts
  always_comb begin
    multSum   = {1'b0, accHi} + (accLo[0] ? {1'b0, mcand} : 33'd0);
    divShift  = {accHi, accLo[31]};
    divGe     = divShift >= {1'b0, mcand};
    accHiNext = '0;
    accLoNext = '0;
    if (isDiv) begin
      accHiNext = divGe ? (divShift[31:0] - mcand) : divShift[31:0];
      accLoNext = {accLo[30:0], divGe};
    end else begin
      accHiNext = multSum[32:1];
      accLoNext = {multSum[0], accLo[31:1]};
    end
    product = fixSign64({accHiNext, accLoNext}, negQ);
    quot    = fixSign32(accLoNext, negQ);
    rem     = fixSign32(accHiNext, negR);
    hiNext  = product[63:32];
    loNext  = product[31:0];
    if (isDiv) begin
      hiNext = divZero ? dividend : rem;
      loNext = divZero ? 32'hFFFF_FFFF : quot;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= MD_IDLE;
      count    <= '0;
      isDiv    <= 1'b0;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      divZero  <= 1'b0;
      dividend <= '0;
      mcand    <= '0;
      accHi    <= '0;
      accLo    <= '0;
      hiReg    <= '0;
      loReg    <= '0;
    end else if (state == MD_IDLE) begin
      if (start) begin
        state    <= MD_BUSY;
        count    <= '0;
        isDiv    <= op[1];
        negQ     <= isSigned & (a[31] ^ b[31]);
        negR     <= isSigned & a[31];
        divZero  <= op[1] & (b == 32'd0);
        dividend <= a;
        mcand    <= op[1] ? magB : magA;
        accHi    <= '0;
        accLo    <= op[1] ? magA : magB;
      end
    end else begin
      accHi <= accHiNext;
      accLo <= accLoNext;
      count <= count + 1'b1;
      if (count == LAST_STEP) begin
        state <= MD_IDLE;
        hiReg <= hiNext;
        loReg <= loNext;
      end
    end
  end

  assign busy = (state == MD_BUSY);
  assign hi   = hiReg;
  assign lo   = loReg;

endmodule

// File: rtl/execute_stage.sv
// MIPS execute stage: operand muxing, ALU, destination select, EX/MEM register
// and the interlock against unfinished multiply/divide results.
module execute_stage
  import mips_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  execute_stage_if.slave  bus
);

  logic [31:0]        instr_p0, rsData_p0, rtData_p0, imm_p0;
  logic               regDst_p0, memRead_p0, memtoReg_p0, memWrite_p0, aluSrc_p0, regWrite_p0;
  logic [1:0]         aluOp_p0;
  logic [5:0]         funct_p0;
  logic [4:0]         shamt_p0, rtIdx_p0, rdIdx_p0, writeReg_p0;
  logic signed [31:0] opA_p0, opB_p0;
  logic [31:0]        aluRes_p0;
  logic               mdOp_p0, hiLoRead_p0, mdStart_p0, vld_p0;
  logic               mdBusy;
  logic [31:0]        mdHi, mdLo;
  exmeFields_t        exmeNext_p0;
  logic               unusedInstrBits;

  // Stage 0: unpack ID/EX
  assign instr_p0    = bus.IDEXReg[IDEX_INSTR_LSB +: 32];
  assign rsData_p0   = bus.IDEXReg[IDEX_RS_LSB +: 32];
  assign rtData_p0   = bus.IDEXReg[IDEX_RT_LSB +: 32];
  assign imm_p0      = bus.IDEXReg[IDEX_IMM_LSB +: 32];
  assign regDst_p0   = bus.IDEXReg[IDEX_REGDST];
  assign memRead_p0  = bus.IDEXReg[IDEX_MEMREAD];
  assign memtoReg_p0 = bus.IDEXReg[IDEX_MEMTOREG];
  assign aluOp_p0    = bus.IDEXReg[IDEX_ALUOP_LSB +: 2];
  assign memWrite_p0 = bus.IDEXReg[IDEX_MEMWRITE];
  assign aluSrc_p0   = bus.IDEXReg[IDEX_ALUSRC];
  assign regWrite_p0 = bus.IDEXReg[IDEX_REGWRITE];

  assign funct_p0        = instr_p0[5:0];
  assign shamt_p0        = instr_p0[10:6];
  assign rdIdx_p0        = instr_p0[15:11];
  assign rtIdx_p0        = instr_p0[20:16];
  assign unusedInstrBits = ^instr_p0[31:21];

  assign opA_p0      = rsData_p0;
  assign opB_p0      = aluSrc_p0 ? imm_p0 : rtData_p0;
  assign writeReg_p0 = regDst_p0 ? rdIdx_p0 : rtIdx_p0;

  always_comb begin
    aluRes_p0 = '0;
    case (aluOp_p0)
      ALUOP_ADD: aluRes_p0 = opA_p0 + opB_p0;
      ALUOP_SUB: aluRes_p0 = opA_p0 - opB_p0;
      ALUOP_RTYPE: begin
        case (funct_p0)
          FN_ADD, FN_ADDU: aluRes_p0 = opA_p0 + opB_p0;
          FN_SUB, FN_SUBU: aluRes_p0 = opA_p0 - opB_p0;
          FN_AND:  aluRes_p0 = opA_p0 & opB_p0;
          FN_OR:   aluRes_p0 = opA_p0 | opB_p0;
          FN_XOR:  aluRes_p0 = opA_p0 ^ opB_p0;
          FN_NOR:  aluRes_p0 = ~(opA_p0 | opB_p0);
          FN_SLT:  aluRes_p0 = {31'd0, opA_p0 < opB_p0};
          FN_SLTU: aluRes_p0 = {31'd0, $unsigned(opA_p0) < $unsigned(opB_p0)};
          FN_SLL:  aluRes_p0 = $unsigned(opB_p0) << shamt_p0;
          FN_SRL:  aluRes_p0 = $unsigned(opB_p0) >> shamt_p0;
          FN_MFHI: aluRes_p0 = mdHi;
          FN_MFLO: aluRes_p0 = mdLo;
          default: aluRes_p0 = '0;
        endcase
      end
      default: aluRes_p0 = '0;
    endcase
  end

  // Only instructions that touch HI/LO or the unit itself wait for a busy unit
  assign mdOp_p0     = (aluOp_p0 == ALUOP_RTYPE) && isMdFunct(funct_p0);
  assign hiLoRead_p0 = (aluOp_p0 == ALUOP_RTYPE) && (funct_p0 == FN_MFHI || funct_p0 == FN_MFLO);
  assign bus.exStall = mdBusy && (mdOp_p0 || hiLoRead_p0);
  assign vld_p0      = ~bus.exStall;
  assign mdStart_p0  = mdOp_p0 && vld_p0;

  muldiv_unit #(.MD_CYCLES(MD_CYCLES)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdStart_p0),
    .op    (funct_p0[1:0]),
    .a     (rsData_p0),
    .b     (rtData_p0),
    .busy  (mdBusy),
    .hi    (mdHi),
    .lo    (mdLo)
  );

  always_comb begin
    exmeNext_p0           = '0;
    exmeNext_p0.memRead   = memRead_p0;
    exmeNext_p0.memtoReg  = memtoReg_p0;
    exmeNext_p0.memWrite  = memWrite_p0;
    exmeNext_p0.regWrite  = regWrite_p0 & ~mdOp_p0;
    exmeNext_p0.writeReg  = writeReg_p0;
    exmeNext_p0.storeData = rtData_p0;
    exmeNext_p0.aluResult = aluRes_p0;
  end

  // Stage 1: EX/MEM register, bubble while stalled
  always_ff @(posedge clk) begin
    if (!rst_n)
      bus.EXMEReg <= '0;
    else if (!vld_p0)
      bus.EXMEReg <= '0;
    else
      bus.EXMEReg <= exmeNext_p0;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode/write-back stage. Consumes the 136-bit ID/EX register, performs ALU operations and destination-register selection, and produces the 75-bit EX/MEM register used by the memory stage and by decode-stage branch forwarding. Contains a 32-cycle iterative multiply/divide unit with HI/LO registers. An interlock stalls upstream stages only when a later instruction depends on an unfinished multiply/divide.

## Interface
- `MD_CYCLES`, default 32: number of iterations per multiply/divide. Fixed at 32 for 32-bit operands.
- `clk`, input, 1: the single clock. All state updates on its rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `IDEXReg`, input, 136: the ID/EX pipeline register.
  - [31:0] instruction.
  - [63:32] readData1 (rs).
  - [95:64] readData2 (rt).
  - [127:96] sign-extended immediate.
  - [135:128] control: RegDst 135, MemRead 134, MemtoReg 133, ALUOp 132:131, MemWrite 130, ALUSrc 129, RegWrite 128.
- `EXMEReg`, output reg, 75: the EX/MEM pipeline register.
  - [31:0] ALU result.
  - [63:32] store data (readData2).
  - [68:64] write register.
  - [69] RegWrite.
  - [70] MemWrite.
  - [71] MemtoReg.
  - [72] MemRead.
  - [74:73] reserved, always 0.
- `exStall`, output, 1: combinational. While high, upstream must hold the PC, IF/ID and ID/EX registers.

## Operation
- Operand B is the immediate when ALUSrc=1, otherwise readData2. Write register is rd [15:11] when RegDst=1, otherwise rt [20:16].
- ALUOp encodings:
  - 00: add (lw/sw).
  - 01: subtract.
  - 11: result 0.
  - 10: decode funct [5:0]:
    - 0x20/0x21: add.
    - 0x22/0x23: sub.
    - 0x24: and.
    - 0x25: or.
    - 0x26: xor.
    - 0x27: nor.
    - 0x2A: slt (signed).
    - 0x2B: sltu.
    - 0x00: sll by shamt [10:6].
    - 0x02: srl by shamt [10:6].
    - 0x10: MFHI, result = HI.
    - 0x12: MFLO, result = LO.
    - 0x18/0x19/0x1A/0x1B: MULT/MULTU/DIV/DIVU.
    - Any other funct: result 0.
- Arithmetic is modulo 2^32. Overflow is ignored; no exceptions are raised.
- MULT/MULTU/DIV/DIVU start the multiply/divide unit. The instruction still advances, with RegWrite forced to 0 in EXMEReg.
- Multiply/divide FSM:
  - States: IDLE and BUSY.
  - IDLE → BUSY on a clock edge with a start op in ID/EX and exStall=0. Operands are latched and counter is cleared.
  - In BUSY: one shift-add (multiply) or one restoring-divide step per cycle.
  - After step MD_CYCLES: HI/LO are written at the same edge that returns the FSM to IDLE.
  - Signed ops run on magnitudes; the result sign is fixed afterwards.
  - DIV: the remainder takes the sign of the dividend.
  - Divide by zero: HI = dividend, LO = 0xFFFFFFFF.
- exStall = (state==BUSY) AND (ID/EX holds MFHI, MFLO, or a multiply/divide op, with ALUOp=10).
  - While exStall is high, EXMEReg loads all zeros (a bubble) and no new operation starts.
  - Independent instructions keep flowing while the unit is BUSY.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - EXMEReg = 0, HI = 0, LO = 0.
  - FSM to IDLE, counter to 0.
  - exStall therefore reads 0 after that edge.
- Reset while BUSY aborts the operation; HI/LO stay 0.
- ALU path latency: 1 cycle. IDEXReg sampled at edge N appears on EXMEReg after edge N.
- Multiply/divide issued at edge N:
  - FSM is BUSY from N to N+32.
  - HI/LO are valid after edge N+32.
  - A dependent MFHI/MFLO sitting in ID/EX from cycle N+1 sees exStall high for exactly 32 cycles. It samples the new HI/LO at edge N+33.
- A back-to-back multiply/divide waits for the previous one to finish and starts at edge N+33.
- All-zero control bits (a decode bubble) produce an EXMEReg with RegWrite=MemWrite=MemRead=0.

## Structure
- Shared package `mips_pkg` holds:
  - Funct and ALUOp constants.
  - IDEXReg/EXMEReg field bit positions and widths.
  - The MD_CYCLES default.
- One sub-module, `muldiv_unit`, holds the FSM, counter, operand/partial registers and HI/LO. Its interface:
  - Inputs: start, op[1:0], a, b.
  - Outputs: busy, hi, lo.
- ALU, operand muxing, write-register selection, the EXMEReg register and stall logic stay in `execute_stage`.

## Test plan
- R-type add: readData1=5, readData2=7, rd=3, RegWrite=1 → next cycle EXMEReg[31:0]=12, [68:64]=3, [69]=1.
- lw with ALUSrc=1: base 0x100, imm 0xFFFFFFFC → ALU result 0xFC, [72]=1, write register = rt.
- MULT 0xFFFFFFFF × 2 followed by MFLO → exStall high for 32 cycles, then LO result 0xFFFFFFFE; MFHI afterwards gives 0xFFFFFFFF.
- DIVU 7/0 → HI=7, LO=0xFFFFFFFF. DIV −7/2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- MULTU followed by an independent addu → no stall; addu result appears one cycle later.
- rst_n low at cycle 10 of a DIV → EXMEReg=0, HI=LO=0, exStall=0 after the edge; a later MFHI returns 0 without stalling.
